lsu_dmem_stage: RTL and testbench

//  Parametrised MEM stage and data memory for the RV32 pipeline. Sits between execute and write-back.

---
 rtl/lsu_dmem_stage.sv | 224 ++++++++++++++++++++++
 tb/tb_lsu_dmem_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_stage.sv
// MEM stage with byte-addressed data memory, alignment checking, optional
// access wait states and a registered write-back output.

package riscv_pkg;
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BNE,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
  } operation_e;
endpackage

module lsu_dmem_stage
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  operation_e      operation_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      rf_addr_i,
  input  logic            rf_write_enable_i,
  input  logic [XLEN-1:0] rf_data_i,
  output logic            wb_valid_o,
  output logic [4:0]      rf_addr_o,
  output logic            rf_write_enable_o,
  output logic [XLEN-1:0] rf_data_o,
  output logic            misalign_o
);

  localparam int  IDX_W    = $clog2(MEM_WORDS);
  localparam bit  HAS_WAIT = (WAIT_STATES != 0);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e          state, state_n;
  logic [2:0]      cnt, cnt_n;

  operation_e      cap_op;
  logic [XLEN-1:0] cap_addr, cap_wdata, cap_rf_data;
  logic [4:0]      cap_rf_addr;
  logic            cap_rf_we;

  operation_e      cur_op;
  logic [XLEN-1:0] cur_addr, cur_wdata, cur_rf_data;
  logic [4:0]      cur_rf_addr;
  logic            cur_rf_we;

  logic            is_load, is_store, is_mem, is_unsigned, misaligned;
  logic [1:0]      size_sel;
  logic [1:0]      lane;
  logic [IDX_W-1:0] mem_idx;
  logic [3:0]      byte_en;
  logic [XLEN-1:0] store_data, rd_word, rd_shifted, load_data;

  logic            accept, capture, commit, wb_fire;
  logic            unused_addr_bits;

  logic [XLEN-1:0] mem [MEM_WORDS];

  // While an access waits, the captured request drives the datapath; in IDLE the live inputs do.
  always_comb begin
    if (state == WAIT) begin
      cur_op      = cap_op;
      cur_addr    = cap_addr;
      cur_wdata   = cap_wdata;
      cur_rf_addr = cap_rf_addr;
      cur_rf_we   = cap_rf_we;
      cur_rf_data = cap_rf_data;
    end else begin
      cur_op      = operation_i;
      cur_addr    = addr_i;
      cur_wdata   = wdata_i;
      cur_rf_addr = rf_addr_i;
      cur_rf_we   = rf_write_enable_i;
      cur_rf_data = rf_data_i;
    end
  end

  assign lane             = cur_addr[1:0];
  assign mem_idx          = cur_addr[2 +: IDX_W];
  assign unused_addr_bits = ^cur_addr[XLEN-1:IDX_W+2];

  // size_sel: 0 = byte, 1 = halfword, 2 = word
  always_comb begin
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_unsigned = 1'b0;
    size_sel    = 2'd0;
    case (cur_op)
      OP_LB:  is_load = 1'b1;
      OP_LH:  begin is_load = 1'b1; size_sel = 2'd1; end
      OP_LW:  begin is_load = 1'b1; size_sel = 2'd2; end
      OP_LBU: begin is_load = 1'b1; is_unsigned = 1'b1; end
      OP_LHU: begin is_load = 1'b1; is_unsigned = 1'b1; size_sel = 2'd1; end
      OP_SB:  is_store = 1'b1;
      OP_SH:  begin is_store = 1'b1; size_sel = 2'd1; end
      OP_SW:  begin is_store = 1'b1; size_sel = 2'd2; end
      default: ;
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign misaligned = is_mem &&
                      (((size_sel == 2'd1) && lane[0]) ||
                       ((size_sel == 2'd2) && (lane != 2'd0)));

  always_comb begin
    byte_en    = 4'b1111;
    store_data = cur_wdata;
    case (size_sel)
      2'd0: begin
        byte_en    = 4'b0001 << lane;
        store_data = {4{cur_wdata[7:0]}};
      end
      2'd1: begin
        byte_en    = 4'b0011 << {lane[1], 1'b0};
        store_data = {2{cur_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign rd_word    = mem[mem_idx];
  assign rd_shifted = rd_word >> {lane, 3'b000};

  always_comb begin
    load_data = rd_word;
    case (size_sel)
      2'd0: load_data = is_unsigned ? {{(XLEN-8){1'b0}}, rd_shifted[7:0]}
                                    : {{(XLEN-8){rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1: load_data = is_unsigned ? {{(XLEN-16){1'b0}}, rd_shifted[15:0]}
                                    : {{(XLEN-16){rd_shifted[15]}}, rd_shifted[15:0]};
      default: ;
    endcase
  end

  assign req_ready_o = (state == IDLE) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    commit  = 1'b0;
    wb_fire = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          capture = 1'b1;
          if (is_mem && !misaligned && HAS_WAIT) begin
            state_n = WAIT;
            cnt_n   = 3'(WAIT_STATES);
          end else begin
            wb_fire = 1'b1;
            commit  = is_mem && !misaligned;
          end
        end
      end
      WAIT: begin
        cnt_n = cnt - 3'd1;
        if (cnt == 3'd1) begin
          commit  = 1'b1;
          wb_fire = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= IDLE;
      cnt               <= 3'd0;
      cap_op            <= OP_ADD;
      cap_addr          <= '0;
      cap_wdata         <= '0;
      cap_rf_addr       <= '0;
      cap_rf_we         <= 1'b0;
      cap_rf_data       <= '0;
      wb_valid_o        <= 1'b0;
      rf_addr_o         <= '0;
      rf_write_enable_o <= 1'b0;
      rf_data_o         <= '0;
      misalign_o        <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (capture) begin
        cap_op      <= operation_i;
        cap_addr    <= addr_i;
        cap_wdata   <= wdata_i;
        cap_rf_addr <= rf_addr_i;
        cap_rf_we   <= rf_write_enable_i;
        cap_rf_data <= rf_data_i;
      end
      wb_valid_o        <= wb_fire;
      rf_write_enable_o <= wb_fire && cur_rf_we && !misaligned;
      misalign_o        <= wb_fire && misaligned;
      if (wb_fire) begin
        rf_addr_o <= cur_rf_addr;
        if (misaligned)   rf_data_o <= '0;
        else if (is_load) rf_data_o <= load_data;
        else              rf_data_o <= cur_rf_data;
      end
    end
  end

  // Memory contents survive reset; reset only suppresses a commit in the same cycle.
  always_ff @(posedge clk_i) begin
    if (commit && is_store && !rst_i) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[mem_idx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_lsu_dmem_stage.sv
// Randomised bench for lsu_dmem_stage: two instances (0 and 3 wait states)
// checked against a byte-array memory model.

module tb_lsu_dmem_stage;
  import riscv_pkg::*;

  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        req_valid [2];
  logic        req_ready [2];
  operation_e  op [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [4:0]  rf_addr_in [2];
  logic        rf_we_in [2];
  logic [31:0] rf_data_in [2];
  logic        wb_valid [2];
  logic [4:0]  rf_addr_out [2];
  logic        rf_we_out [2];
  logic [31:0] rf_data_out [2];
  logic        misalign [2];

  logic [7:0]  mmod [2][4096];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  lsu_dmem_stage #(.XLEN(32), .MEM_WORDS(1024), .WAIT_STATES(WS0)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .operation_i(op[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .rf_addr_i(rf_addr_in[0]),
    .rf_write_enable_i(rf_we_in[0]), .rf_data_i(rf_data_in[0]), .wb_valid_o(wb_valid[0]),
    .rf_addr_o(rf_addr_out[0]), .rf_write_enable_o(rf_we_out[0]), .rf_data_o(rf_data_out[0]),
    .misalign_o(misalign[0]));

  lsu_dmem_stage #(.XLEN(32), .MEM_WORDS(1024), .WAIT_STATES(WS1)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .operation_i(op[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .rf_addr_i(rf_addr_in[1]),
    .rf_write_enable_i(rf_we_in[1]), .rf_data_i(rf_data_in[1]), .wb_valid_o(wb_valid[1]),
    .rf_addr_o(rf_addr_out[1]), .rf_write_enable_o(rf_we_out[1]), .rf_data_o(rf_data_out[1]),
    .misalign_o(misalign[1]));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int accessSize(input operation_e o);
    case (o)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit isLoad(input operation_e o);
    return o inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic bit isStore(input operation_e o);
    return o inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic bit isMisaligned(input operation_e o, input logic [31:0] a);
    int sz = accessSize(o);
    return (sz > 1) && ((a % sz) != 0);
  endfunction

  function automatic logic [31:0] modelLoad(input int d, input operation_e o, input logic [31:0] a);
    int    sz   = accessSize(o);
    int    base = int'(a % 4096);
    longint v   = 0;
    for (int i = 0; i < sz; i++) v += longint'(mmod[d][base + i]) << (8 * i);
    if (o inside {OP_LB, OP_LH} && v >= (longint'(1) << (8 * sz - 1)))
      v -= (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  task automatic modelStore(input int d, input operation_e o, input logic [31:0] a, input logic [31:0] w);
    int base = int'(a % 4096);
    for (int i = 0; i < accessSize(o); i++) mmod[d][base + i] = 8'((w >> (8 * i)) & 32'hFF);
  endtask

  // One complete transaction: accept, wait for write-back with a bound, compare, update model.
  task automatic applyStimulus(input int d, input operation_e o, input logic [31:0] a,
                               input logic [31:0] w, input logic [4:0] ra, input logic rwe,
                               input logic [31:0] rd, output logic [31:0] got);
    bit          mis    = isMisaligned(o, a);
    bit          memop  = isLoad(o) || isStore(o);
    int          ws     = (d == 0) ? WS0 : WS1;
    int          lat    = (memop && !mis) ? 1 + ws : 1;
    logic [31:0] exp_d  = mis ? 32'h0 : (isLoad(o) ? modelLoad(d, o, a) : rd);
    int          n = 0, busy = 0, stray = 0;
    bit          seen = 0;
    @(negedge clk);
    op[d] = o; addr[d] = a; wdata[d] = w; rf_addr_in[d] = ra; rf_we_in[d] = rwe;
    rf_data_in[d] = rd; req_valid[d] = 1'b1;
    checkOutput("ready_idle", req_ready[d], 1);
    @(posedge clk);
    #1;
    op[d] = operation_e'(5'($urandom_range(0, 23)));
    addr[d] = $urandom; wdata[d] = $urandom; rf_data_in[d] = $urandom;
    rf_addr_in[d] = 5'($urandom); rf_we_in[d] = 1'($urandom);
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (wb_valid[d]) begin
        seen = 1; n = i;
      end else begin
        if (!req_ready[d]) busy++;
        if (rf_we_out[d] || misalign[d]) stray++;
      end
    end
    req_valid[d] = 1'b0;
    checkOutput("wb_seen", 32'(seen), 1);
    checkOutput("latency", n, lat);
    checkOutput("busy_cycles", busy, lat - 1);
    checkOutput("idle_strobes", stray, 0);
    checkOutput("rf_data", rf_data_out[d], exp_d);
    checkOutput("rf_we", rf_we_out[d], 32'(rwe && !mis));
    checkOutput("misalign", misalign[d], 32'(mis));
    checkOutput("rf_addr", rf_addr_out[d], 32'(ra));
    got = rf_data_out[d];
    if (isStore(o) && !mis) modelStore(d, o, a, w);
    @(negedge clk);
    checkOutput("wb_pulse", wb_valid[d], 0);
    checkOutput("we_after", {rf_we_out[d], misalign[d]}, 0);
    checkOutput("data_hold", rf_data_out[d], got);
  endtask

  task automatic resetDut(input int d);
    @(negedge clk);
    rst[d] = 1'b1; req_valid[d] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ctrl", {wb_valid[d], rf_we_out[d], misalign[d], req_ready[d], rf_addr_out[d]}, 0);
    checkOutput("rst_data", rf_data_out[d], 0);
    @(negedge clk);
    rst[d] = 1'b0;
    #1;
    checkOutput("ready_after_rst", req_ready[d], 1);
  endtask

  // Store interrupted by reset in its second wait cycle must never commit.
  task automatic abortStore(input int d);
    logic [31:0] old_w = modelLoad(d, OP_LW, 32'h20);
    logic [31:0] got;
    int          wb_seen = 0;
    @(negedge clk);
    op[d] = OP_SW; addr[d] = 32'h20; wdata[d] = ~old_w; rf_addr_in[d] = 5'd3;
    rf_we_in[d] = 1'b0; rf_data_in[d] = 32'h0; req_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    @(posedge clk);
    #1;
    rst[d] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (wb_valid[d]) wb_seen++;
    end
    checkOutput("abort_rst_ctrl", {wb_valid[d], rf_we_out[d], misalign[d], req_ready[d], rf_addr_out[d]}, 0);
    checkOutput("abort_rst_data", rf_data_out[d], 0);
    rst[d] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (wb_valid[d]) wb_seen++;
    end
    checkOutput("abort_no_wb", wb_seen, 0);
    applyStimulus(d, OP_LW, 32'h20, 32'h0, 5'd4, 1'b1, 32'h0, got);
    checkOutput("abort_old_data", got, old_w);
  endtask

  task automatic runDut(input int d);
    logic [31:0] got;
    operation_e  o;
    logic [31:0] a;
    resetDut(d);
    for (int w = 0; w < 16; w++)
      applyStimulus(d, OP_SW, ($urandom & 32'hFFFF_F000) | 32'(w * 4), $urandom,
                    5'($urandom), 1'b0, 32'h0, got);

    applyStimulus(d, OP_SW, 32'h10, 32'hDEADBEEF, 5'd1, 1'b0, 32'h0, got);
    applyStimulus(d, OP_LW, 32'h10, 32'h0, 5'd2, 1'b1, 32'h12345678, got);
    checkOutput("t1_lw", got, 32'hDEADBEEF);
    applyStimulus(d, OP_SW, 32'h10, 32'h11223344, 5'd1, 1'b0, 32'h0, got);
    applyStimulus(d, OP_SB, 32'h13, 32'hABCDEF80, 5'd1, 1'b0, 32'h0, got);
    applyStimulus(d, OP_LB, 32'h13, 32'h0, 5'd5, 1'b1, 32'h0, got);
    checkOutput("t2_lb", got, 32'hFFFFFF80);
    applyStimulus(d, OP_LBU, 32'h13, 32'h0, 5'd6, 1'b1, 32'h0, got);
    checkOutput("t2_lbu", got, 32'h00000080);
    applyStimulus(d, OP_LW, 32'h10, 32'h0, 5'd7, 1'b1, 32'h0, got);
    checkOutput("t2_lw", got, 32'h80223344);
    applyStimulus(d, OP_SH, 32'h12, 32'h5A5A1234, 5'd8, 1'b0, 32'h0, got);
    applyStimulus(d, OP_LW, 32'h10, 32'h0, 5'd9, 1'b1, 32'h0, got);
    checkOutput("t3_sh_word", got, 32'h12343344);
    applyStimulus(d, OP_LW, 32'h06, 32'h0, 5'd10, 1'b1, 32'h0, got);
    applyStimulus(d, OP_SW, 32'h06, 32'hFFFFFFFF, 5'd10, 1'b0, 32'h0, got);
    applyStimulus(d, OP_LW, 32'h04, 32'h0, 5'd11, 1'b1, 32'h0, got);
    applyStimulus(d, OP_SW, 32'h00001000, 32'hCAFEF00D, 5'd12, 1'b0, 32'h0, got);
    applyStimulus(d, OP_LW, 32'h0, 32'h0, 5'd13, 1'b1, 32'h0, got);
    checkOutput("t6_wrap", got, 32'hCAFEF00D);
    applyStimulus(d, OP_ADD, 32'h1234, 32'h0, 5'd14, 1'b1, 32'h5, got);
    checkOutput("t6_add", got, 32'h5);

    if (d == 1) abortStore(d);

    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 9) < 7) o = operation_e'(5'(int'(OP_LB) + $urandom_range(0, 7)));
      else                          o = operation_e'(5'($urandom_range(0, 15)));
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      applyStimulus(d, o, a, $urandom, 5'($urandom), 1'($urandom), $urandom, got);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; op[d] = OP_ADD; addr[d] = '0; wdata[d] = '0;
      rf_addr_in[d] = '0; rf_we_in[d] = 1'b0; rf_data_in[d] = '0;
    end
    for (int d = 0; d < 2; d++) runDut(d);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] time limit");
  end

endmodule
